// File: rtl/dm_bridge.sv
// Data-memory bridge: CPU load/store -> word-wide ready-handshake bus; optional abort via DM_TIMEOUT_EN.
// Latency: IDLE capture + REQ (1 + bus wait cycles) + DONE commit; zero-wait access stalls 2 cycles.
// Backpressure: bus_req held until bus_ready; cpu_stall freezes the core until DONE.
module dm_bridge #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  if (2**CNT_W <= TIMEOUT) begin : g_cnt_w_check
    $error("dm_bridge: CNT_W too narrow for TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic        is_half, is_byte, is_word;
  logic        accept, tmo;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] rd_shift, load_ext;

  logic [29:0] word_addr_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic [2:0]  ctrl_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // 101-111 fall through to word size
  assign is_half = (dm_ctrl == 3'b001) || (dm_ctrl == 3'b010);
  assign is_byte = (dm_ctrl == 3'b011) || (dm_ctrl == 3'b100);
  assign is_word = ~is_half & ~is_byte;

  assign misalign  = cpu_req & ((is_half & cpu_addr[0]) | (is_word & (|cpu_addr[1:0])));
  assign accept    = cpu_req & ~misalign;
  assign cpu_stall = accept & (state != DONE);

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = cpu_wdata;
    if (is_half) begin
      be_nxt    = 4'b0011 << cpu_addr[1:0];
      wdata_nxt = {2{cpu_wdata[15:0]}};
    end else if (is_byte) begin
      be_nxt    = 4'b0001 << cpu_addr[1:0];
      wdata_nxt = {4{cpu_wdata[7:0]}};
    end
  end

  assign rd_shift = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = rd_shift;
    case (ctrl_q)
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_ext = {16'h0000, rd_shift[15:0]};
      3'b011:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_ext = {24'h000000, rd_shift[7:0]};
      default: load_ext = rd_shift;
    endcase
  end

`ifdef DM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q;

  // Abort on the TIMEOUT-th REQ cycle that still lacks bus_ready
  assign tmo = (state == REQ) & ~bus_ready & (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state == IDLE && accept) begin
      cnt_q <= '0;
    end else if (state == REQ) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (bus_ready || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_addr_q <= '0;
      off_q       <= '0;
      we_q        <= 1'b0;
      ctrl_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else if (state == IDLE && accept) begin
      word_addr_q <= cpu_addr[31:2];
      off_q       <= cpu_addr[1:0];
      we_q        <= cpu_we;
      ctrl_q      <= dm_ctrl;
      be_q        <= be_nxt;
      wdata_q     <= wdata_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo;
      if (tmo) begin
        rdata_q <= '0;
      end else if (state == REQ && bus_ready && !we_q) begin
        rdata_q <= load_ext;
      end
    end
  end

  // Misaligned accesses commit in the same cycle, so zero is forced combinationally
  assign cpu_rdata = misalign ? 32'h0 : rdata_q;
  assign bus_err   = err_q;
  assign bus_req   = (state == REQ);
  assign bus_we    = we_q & bus_req;
  assign bus_addr  = {word_addr_q, 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule
